// File: rtl/uart_mux_pkg.sv
// Shared constants for the UART transmit arbiter: FSM state encoding,
// parameter defaults and the channel-tag helper.
package uart_mux_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      HDR_START = 3'd1,
      HDR_WAIT  = 3'd2,
      LOAD      = 3'd3,
      START     = 3'd4,
      WAIT      = 3'd5
   } state_t;

   localparam logic [7:0]  TAG_BASE_DEF = 8'hA0;
   localparam logic [15:0] GAP_MAX_DEF  = 16'd1024;

   // Channel index occupies the low bits of the tag byte (NUM_CH <= 8).
   function automatic logic [7:0] tag_byte(input logic [7:0] base, input logic [2:0] ch);
      return base | {5'b0_0000, ch};
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin search: first set request strictly after `last`, wrapping.
// Purely combinational; the caller registers the chosen index.
module rr_arbiter #(
   parameter int NUM_CH = 4,
   localparam int GW = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [GW-1:0]     last,
   output logic [GW-1:0]     gnt,
   output logic              gnt_valid
);

   int idx;

   // Scan from the farthest offset down so the nearest requester wins.
   always_comb begin
      gnt       = '0;
      gnt_valid = 1'b0;
      idx       = 0;
      for (int k = NUM_CH; k >= 1; k--) begin
         idx = (int'(last) + k) % NUM_CH;
         if (req[idx]) begin
            gnt       = GW'(idx);
            gnt_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Multiplexes byte-stream frames from NUM_CH requesters onto one UART
// transmitter, optionally prefixing each frame with a channel tag byte.
module uart_tx_arbiter
   import uart_mux_pkg::*;
#(
   parameter int          NUM_CH   = 4,
   parameter bit          TAG_EN   = 1'b1,
   parameter logic [7:0]  TAG_BASE = TAG_BASE_DEF,
   parameter logic [15:0] GAP_MAX  = GAP_MAX_DEF,
   localparam int GW = $clog2(NUM_CH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [NUM_CH-1:0]     req_valid,
   input  logic [NUM_CH-1:0]     req_last,
   input  logic [NUM_CH*8-1:0]   req_data,
   output logic [NUM_CH-1:0]     req_ready,
   output logic                  tx_start,
   output logic [7:0]            tx_data,
   input  logic                  tx_done_tick,
   output logic                  busy,
   output logic [GW-1:0]         grant_ch,
   output logic                  abort_tick
);

   state_t        state, state_nxt;
   logic [GW-1:0] last_grant;
   logic          last_q;
   logic [15:0]   gap_cnt;

   logic [GW-1:0] arb_gnt;
   logic          arb_valid;

   logic          sel_valid;
   logic          sel_last;
   logic [7:0]    sel_data;

   logic          take_grant;
   logic          accept;
   logic          gap_inc;
   logic          frame_end;

   rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
      .req       (req_valid),
      .last      (last_grant),
      .gnt       (arb_gnt),
      .gnt_valid (arb_valid)
   );

   assign sel_valid = req_valid[grant_ch];
   assign sel_last  = req_last[grant_ch];
   assign sel_data  = req_data[{grant_ch, 3'b000} +: 8];
   assign busy      = (state != IDLE);

   always_comb begin
      state_nxt  = state;
      tx_start   = 1'b0;
      req_ready  = '0;
      abort_tick = 1'b0;
      take_grant = 1'b0;
      accept     = 1'b0;
      gap_inc    = 1'b0;
      frame_end  = 1'b0;
      case (state)
         IDLE: begin
            if (enable && arb_valid) begin
               take_grant = 1'b1;
               state_nxt  = TAG_EN ? HDR_START : LOAD;
            end
         end
         HDR_START: begin
            tx_start  = 1'b1;
            state_nxt = HDR_WAIT;
         end
         HDR_WAIT: begin
            if (tx_done_tick) state_nxt = LOAD;
         end
         LOAD: begin
            if (sel_valid) begin
               req_ready[grant_ch] = 1'b1;
               accept              = 1'b1;
               state_nxt           = START;
            end else if (({1'b0, gap_cnt} + 17'd1) >= {1'b0, GAP_MAX}) begin
               // Requester went silent mid-frame for too long: give up the grant.
               abort_tick = 1'b1;
               state_nxt  = IDLE;
            end else begin
               gap_inc = 1'b1;
            end
         end
         START: begin
            tx_start  = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (tx_done_tick) begin
               if (last_q) begin
                  frame_end = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = LOAD;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         grant_ch   <= GW'(NUM_CH - 1);
         last_grant <= GW'(NUM_CH - 1);
         tx_data    <= 8'h00;
         last_q     <= 1'b0;
         gap_cnt    <= '0;
      end else begin
         state <= state_nxt;
         if (take_grant) begin
            grant_ch <= arb_gnt;
            if (TAG_EN) tx_data <= tag_byte(TAG_BASE, 3'(arb_gnt));
         end
         if (accept) begin
            tx_data <= sel_data;
            last_q  <= sel_last;
            gap_cnt <= '0;
         end else if (abort_tick) begin
            gap_cnt    <= '0;
            last_grant <= grant_ch;
         end else if (gap_inc) begin
            gap_cnt <= gap_cnt + 16'd1;
         end
         if (frame_end) last_grant <= grant_ch;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes expected UART bytes,
// a negedge monitor pops and compares on every tx_start.
module tb_uart_tx_arbiter;

   localparam int         NCH      = 4;
   localparam logic [7:0] TAG_BASE = 8'hA0;

   logic             clk = 1'b0;
   logic             reset;
   logic             enable;
   logic [NCH-1:0]   req_valid;
   logic [NCH-1:0]   req_last;
   logic [NCH*8-1:0] req_data;
   logic [NCH-1:0]   req_ready;
   logic             tx_start;
   logic [7:0]       tx_data;
   logic             tx_done_tick;
   logic             busy;
   logic [1:0]       grant_ch;
   logic             abort_tick;
   logic             uart_done;
   logic             spur;

   assign tx_done_tick = uart_done | spur;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_CH(NCH), .TAG_EN(1'b1), .TAG_BASE(8'hA0), .GAP_MAX(16'd8)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
      .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
      .tx_done_tick(tx_done_tick), .busy(busy), .grant_ch(grant_ch),
      .abort_tick(abort_tick)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];

   // Per-channel byte streams offered by the requesters.
   logic [7:0] cb[NCH][128];
   bit         cl[NCH][128];
   int         cn[NCH];
   int         cp[NCH];
   int         srun[NCH];
   bit         mid[NCH];
   bit         stall_en = 1'b0;
   logic [NCH-1:0] hs = '0;

   int   n_start = 0, n_done = 0, n_abort = 0, cyc = 0;
   int   last_done_cyc = 0, abort_gap = 0;
   bit   in_flight = 1'b0, abort_ok = 1'b0;
   logic [7:0] held = 8'h00;
   int   model_last = NCH - 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   // Transmitter model: done pulse 1..4 cycles after each start.
   initial begin
      uart_done = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start && reset) begin
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1 uart_done = 1'b1;
            @(posedge clk);
            #1 uart_done = 1'b0;
         end
      end
   end

   // Monitor / scoreboard.
   always @(negedge clk) begin
      cyc++;
      hs = req_ready & req_valid & {NCH{reset}};
      if (reset) begin
         checks++;
         if (((req_ready & ~req_valid) != 0) || !$onehot0(req_ready) ||
             ((req_ready != 0) && (req_ready != (NCH'(1) << grant_ch))) ||
             (!busy && ((req_ready != 0) || tx_start))) begin
            errors++;
            $display("FAIL invariant: req_ready=%b req_valid=%b grant=%0d busy=%0b tx_start=%0b at cycle %0d",
                     req_ready, req_valid, grant_ch, busy, tx_start, cyc);
         end
         if (tx_start) begin
            n_start++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_tx_start: got byte %02h, required no transmission", tx_data);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               if (tx_data !== e) begin
                  errors++;
                  $display("FAIL tx_byte: got %02h required %02h", tx_data, e);
               end
            end
            held      = tx_data;
            in_flight = 1'b1;
         end else if (in_flight && tx_done_tick) begin
            checks++;
            if (tx_data !== held) begin
               errors++;
               $display("FAIL tx_data_stable: got %02h required %02h", tx_data, held);
            end
            in_flight     = 1'b0;
            last_done_cyc = cyc;
            n_done++;
         end
         if (abort_tick) begin
            n_abort++;
            abort_gap = cyc - last_done_cyc;
            checks++;
            if (!abort_ok) begin
               errors++;
               $display("FAIL unexpected_abort: got abort_tick=1 required 0 at cycle %0d", cyc);
            end
         end
      end else begin
         in_flight = 1'b0;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   // One clock: advance the requesters past accepted bytes, then drive.
   task automatic step();
      bit v;
      @(posedge clk);
      #1;
      for (int i = 0; i < NCH; i++) begin
         if (hs[i]) begin
            mid[i] = !cl[i][cp[i]];
            cp[i]++;
         end
         if (stall_en && mid[i] && cp[i] < cn[i] && srun[i] < 3 && $urandom_range(0, 2) == 0) begin
            srun[i]++;
            v = 1'b0;
         end else begin
            srun[i] = 0;
            v = (cp[i] < cn[i]);
         end
         req_valid[i]       = v;
         req_data[i*8 +: 8] = (cp[i] < cn[i]) ? cb[i][cp[i]] : 8'h00;
         req_last[i]        = (cp[i] < cn[i]) ? cl[i][cp[i]] : 1'b0;
      end
   endtask

   task automatic add_byte(input int ch, input logic [7:0] b, input bit last);
      cb[ch][cn[ch]] = b;
      cl[ch][cn[ch]] = last;
      cn[ch]++;
      if (cp[ch] == cn[ch] - 1) mid[ch] = 1'b0;
   endtask

   task automatic add_frame(input int ch, input int len);
      for (int k = 0; k < len; k++) add_byte(ch, 8'($urandom), k == len - 1);
   endtask

   function automatic bit drained();
      for (int i = 0; i < NCH; i++) if (cp[i] < cn[i]) return 1'b0;
      return 1'b1;
   endfunction

   // Reference: round-robin over channels with pending frames, whole frames at a time.
   task automatic build_expect();
      int pos[NCH];
      int sel;
      for (int i = 0; i < NCH; i++) pos[i] = cp[i];
      while (1) begin
         sel = -1;
         for (int k = 1; k <= NCH && sel < 0; k++)
            if (pos[(model_last + k) % NCH] < cn[(model_last + k) % NCH]) sel = (model_last + k) % NCH;
         if (sel < 0) break;
         exp_q.push_back(TAG_BASE | 8'(sel));
         do begin
            exp_q.push_back(cb[sel][pos[sel]]);
            pos[sel]++;
         end while (pos[sel] < cn[sel] && !cl[sel][pos[sel] - 1]);
         model_last = sel;
      end
   endtask

   task automatic wait_drain(input string nm);
      int n = 0;
      while (!(exp_q.size() == 0 && !busy && drained()) && n < 3000) begin
         step();
         n++;
      end
      checks++;
      if (n >= 3000) begin
         errors++;
         $display("FAIL %s_drain: got %0d bytes outstanding, required 0", nm, exp_q.size());
         exp_q.delete();
         for (int i = 0; i < NCH; i++) cp[i] = cn[i];
      end
      step();
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      repeat (2) step();
      reset = 1'b1;
      model_last = NCH - 1;
   endtask

   task automatic check_reset_outputs(input string nm);
      chk({nm, "_tx_start"}, tx_start, 0);
      chk({nm, "_tx_data"}, tx_data, 8'h00);
      chk({nm, "_req_ready"}, req_ready, 0);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_abort"}, abort_tick, 0);
      chk({nm, "_grant"}, grant_ch, NCH - 1);
   endtask

   initial begin
      int s0, a0, d0, n;
      logic [7:0] b;
      reset = 1'b0; enable = 1'b0; spur = 1'b0;
      req_valid = '0; req_last = '0; req_data = '0;
      for (int i = 0; i < NCH; i++) begin
         cn[i] = 0; cp[i] = 0; srun[i] = 0; mid[i] = 1'b0;
      end

      repeat (3) step();
      @(negedge clk);
      check_reset_outputs("reset");
      step();
      reset = 1'b1;
      model_last = NCH - 1;

      // Tagged two-byte frame on channel 0.
      enable = 1'b1;
      add_byte(0, 8'h55, 1'b0);
      add_byte(0, 8'h33, 1'b1);
      s0 = n_start;
      build_expect();
      wait_drain("two_byte");
      chk("two_byte_starts", n_start - s0, 3);
      chk("two_byte_busy", busy, 0);
      chk("two_byte_grant", grant_ch, 0);

      // Round-robin fairness with every channel requesting.
      apply_reset();
      for (int i = 0; i < NCH; i++) begin
         add_frame(i, 1);
         add_frame(i, 1);
      end
      build_expect();
      wait_drain("fairness");
      chk("fairness_grant", grant_ch, 3);

      // Gap timeout on channel 2, then channel 3 is served.
      apply_reset();
      abort_ok = 1'b1;
      a0 = n_abort;
      add_byte(2, 8'h11, 1'b0);
      add_byte(3, 8'h77, 1'b1);
      exp_q.push_back(8'hA2); exp_q.push_back(8'h11);
      exp_q.push_back(8'hA3); exp_q.push_back(8'h77);
      model_last = 3;
      wait_drain("abort");
      chk("abort_count", n_abort - a0, 1);
      chk("abort_gap_cycles", abort_gap, 8);
      chk("abort_next_grant", grant_ch, 3);
      abort_ok = 1'b0;

      // Enable gating of the grant, not of an in-progress frame.
      enable = 1'b0;
      add_frame(1, 3);
      build_expect();
      s0 = n_start;
      repeat (20) step();
      chk("enable_low_starts", n_start - s0, 0);
      chk("enable_low_busy", busy, 0);
      enable = 1'b1;
      @(negedge clk);
      chk("enable_idle_cycle_start", tx_start, 0);
      step();
      @(negedge clk);
      chk("enable_start_latency", tx_start, 1);
      enable = 1'b0;
      wait_drain("enable_midframe");
      enable = 1'b1;

      // Spurious done ticks in IDLE and LOAD.
      s0 = n_start;
      spur = 1'b1;
      step();
      spur = 1'b0;
      step();
      chk("spur_idle_busy", busy, 0);
      chk("spur_idle_starts", n_start - s0, 0);
      b = 8'($urandom);
      add_byte(0, b, 1'b0);
      exp_q.push_back(8'hA0); exp_q.push_back(b);
      d0 = n_done;
      n = 0;
      while ((n_done - d0) < 2 && n < 200) begin
         step();
         n++;
      end
      chk("spur_reach_load", n < 200, 1);
      spur = 1'b1;
      @(negedge clk);
      chk("spur_load_start0", tx_start, 0);
      step();
      spur = 1'b0;
      @(negedge clk);
      chk("spur_load_start1", tx_start, 0);
      chk("spur_load_busy", busy, 1);
      b = 8'($urandom);
      add_byte(0, b, 1'b1);
      exp_q.push_back(b);
      model_last = 0;
      wait_drain("spur_load");

      // Reset while waiting on a data byte; channel 0 wins afterwards.
      add_byte(1, 8'h3C, 1'b0);
      add_byte(1, 8'hC3, 1'b1);
      exp_q.push_back(8'hA1); exp_q.push_back(8'h3C);
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         step();
         n++;
      end
      chk("midreset_reach_wait", n < 200, 1);
      chk("midreset_in_wait", busy, 1);
      reset = 1'b0;
      add_byte(0, 8'h5A, 1'b1);
      step();
      @(negedge clk);
      check_reset_outputs("midreset");
      repeat (5) step();
      reset = 1'b1;
      model_last = NCH - 1;
      build_expect();
      wait_drain("after_reset");
      chk("after_reset_grant", grant_ch, 1);

      // Randomized traffic with short mid-frame stalls.
      apply_reset();
      stall_en = 1'b1;
      for (int r = 0; r < 4; r++) begin
         enable = 1'b0;
         for (int i = 0; i < NCH; i++)
            for (int f = $urandom_range(0, 3); f > 0; f--) add_frame(i, $urandom_range(1, 3));
         build_expect();
         enable = 1'b1;
         wait_drain("random");
      end
      stall_en = 1'b0;
      chk("final_abort_count", n_abort - a0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of requester channels, range 2..8.
REQ-002 SHALL have parameter TAG_EN, default 1: 1 sends a channel tag byte before each frame.
REQ-003 SHALL have parameter TAG_BASE, default 8'hA0: tag byte equals TAG_BASE | channel index.
REQ-004 SHALL have parameter GAP_MAX, default 16'd1024: mid-frame idle cycles allowed before abort.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1: reset is synchronous and active-low.
REQ-007 SHALL have port enable, input, 1: when low, no new grant is issued; an in-progress frame completes.
REQ-008 SHALL have port req_valid, input, NUM_CH: per-channel byte valid.
REQ-009 SHALL have port req_last, input, NUM_CH: per-channel marker for the final byte of a frame.
REQ-010 SHALL have port req_data, input, NUM_CH*8: channel i byte is on bits [8i+7:8i].
REQ-011 SHALL have port req_ready, output, NUM_CH: one-cycle byte-accept strobe per channel.
REQ-012 SHALL have port tx_start, output, 1: one-cycle start pulse to the UART transmitter.
REQ-013 SHALL have port tx_data, output, 8: byte to the transmitter; held stable from tx_start until tx_done_tick.
REQ-014 SHALL have port tx_done_tick, input, 1: transmitter byte-complete pulse.
REQ-015 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-016 SHALL have port grant_ch, output, clog2(NUM_CH): index of the current or last granted channel.
REQ-017 SHALL have port abort_tick, output, 1: one-cycle pulse when a frame is abandoned on gap timeout.

Function
REQ-018 SHALL implement the FSM states IDLE, HDR_START, HDR_WAIT, LOAD, START and WAIT.
REQ-019 SHALL, in IDLE with enable=1 and any req_valid set, grant the first valid channel searching upward from (last_grant+1) mod NUM_CH, with wrap-around.
REQ-020 SHALL make the grant registered: grant_ch updates on the transition out of IDLE, and the next state is HDR_START if TAG_EN=1, else LOAD.
REQ-021 SHALL, in HDR_START, drive tx_data = TAG_BASE | grant_ch and tx_start=1 for exactly one cycle, then go to HDR_WAIT.
REQ-022 SHALL, in HDR_WAIT, stay until tx_done_tick=1, then go to LOAD.
REQ-023 SHALL, in LOAD with req_valid[g]=1: assert req_ready[g] for that cycle only, latch the byte into tx_data, latch req_last[g], clear the gap counter, and go to START.
REQ-024 SHALL, in LOAD with req_valid[g]=0, increment the gap counter; when it reaches GAP_MAX, pulse abort_tick, set last_grant=g, and go to IDLE.
REQ-025 SHALL, in START, assert tx_start for one cycle, then go to WAIT.
REQ-026 SHALL, in WAIT on tx_done_tick: go to IDLE with last_grant=g if the latched last=1, otherwise go to LOAD.
REQ-027 SHALL ignore tx_done_tick in any state other than HDR_WAIT and WAIT.
REQ-028 SHALL keep req_ready of non-granted channels at 0 at all times, and keep req_ready at 0 outside LOAD.
REQ-029 SHALL give a latency of 1 cycle from an IDLE cycle with a valid request to tx_start when TAG_EN=1; when TAG_EN=0, req_ready follows 1 cycle after that IDLE cycle and tx_start 1 cycle after req_ready.
REQ-030 SHALL not preempt a frame; a requester that drops req_valid mid-frame keeps the grant until GAP_MAX is reached.
REQ-031 SHALL ensure that enable deasserting mid-frame does not affect the frame; only the IDLE grant decision is gated.
REQ-032 SHALL grant a single requester repeatedly, back-to-back, with one IDLE cycle between frames.

Reset
REQ-033 SHALL, while reset=0 at a clock edge, go to IDLE with tx_start=0, tx_data=8'h00, req_ready=0, busy=0, abort_tick=0, grant_ch=NUM_CH-1, last_grant=NUM_CH-1, and the gap counter cleared.
REQ-034 SHALL abandon an in-progress frame when reset is applied mid-operation, with no abort_tick pulse; channel 0 has first priority after reset.

Structure
REQ-035 SHALL place the FSM state encodings, the TAG_BASE default and the GAP_MAX default in a shared uart_mux_pkg constants include.
REQ-036 SHALL implement the round-robin search as one sub-module, rr_arbiter (inputs: request vector and last index; output: grant index and grant valid).

Verification
REQ-037 SHALL cover: ch0 sends a 2-byte frame 8'h55,8'h33 (last on the second byte) with TAG_EN=1 -> tx_data sequence A0,55,33, three tx_start pulses, busy=0 after the final tx_done_tick.
REQ-038 SHALL cover: all 4 channels hold 1-byte frames continuously -> tags A0,A1,A2,A3,A0 in order (round-robin fairness).
REQ-039 SHALL cover: ch2 stalls mid-frame with GAP_MAX=8 -> abort_tick after 8 LOAD cycles, next grant goes to ch3.
REQ-040 SHALL cover: enable=0 with requests pending -> no tx_start; enable=1 -> tx_start 1 cycle later.
REQ-041 SHALL cover: reset=0 asserted during WAIT -> next cycle all outputs at reset values, ch0 granted first afterwards.
REQ-042 SHALL cover: spurious tx_done_tick in LOAD or IDLE -> no state change and no tx_start.
